bdd_sweep_ctrl: RTL and testbench



---
 rtl/bdd_sweep_ctrl.sv | 121 ++++++++++++
 tb/tb_bdd_sweep_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bdd_sweep_ctrl.sv
// Exhaustive 3-input truth-table sweeper: drives ABC through 000..111, samples F after a settle time.
// Optional macro BDD_SWEEP_CHECK_EN adds a registered golden-table compare on the match output.
module bdd_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       f_in,
    input  logic [7:0] expected,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth_table,
    output logic       match
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        FINISH
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] tt_q, tt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 8'd0;
            tt_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
        end
    end

    // Abort wins over the sampling edge, so an aborted combination is never captured.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tt_d    = tt_q;
        case (state_q)
            IDLE: begin
                idx_d = 3'd0;
                cnt_d = 8'd0;
                if (start && !abort) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = 3'd0;
                    cnt_d   = 8'd0;
                end else if (cnt_q == CNT_LAST) begin
                    tt_d[idx_q] = f_in;
                    cnt_d       = 8'd0;
                    if (idx_q == 3'd7) begin
                        state_d = FINISH;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            FINISH: begin
                state_d = IDLE;
                idx_d   = 3'd0;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = 3'd0;
                cnt_d   = 8'd0;
            end
        endcase
    end

    assign a_out       = idx_q[2];
    assign b_out       = idx_q[1];
    assign c_out       = idx_q[0];
    assign busy        = (state_q == SETTLE);
    assign done        = (state_q == FINISH);
    assign truth_table = tt_q;

`ifdef BDD_SWEEP_CHECK_EN
    logic match_q;

    // The table is complete by the FINISH cycle; the verdict then holds until the next accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            match_q <= 1'b0;
        end else if (state_q == FINISH) begin
            match_q <= (tt_q == expected);
        end else if (state_q == IDLE && start && !abort) begin
            match_q <= 1'b0;
        end
    end

    assign match = match_q;
`else
    logic unused_expected;
    assign unused_expected = ^expected;
    assign match           = 1'b0;
`endif

endmodule

// File: tb/tb_bdd_sweep_ctrl.sv
// Directed self-checking bench for bdd_sweep_ctrl (SETTLE_CYCLES=4 and SETTLE_CYCLES=1 instances).
`timescale 1ns/1ps
module tb_bdd_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] expected = 8'h00;
    logic       start4 = 1'b0, start1 = 1'b0;
    logic       f4, f1;
    logic       a4, b4, c4, busy4, done4, match4;
    logic       a1, b1, c1, busy1, done1, match1;
    logic [7:0] tt4, tt1;
    int         funcSel = 0;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    bdd_sweep_ctrl #(.SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rstN), .start(start4), .abort(abort), .f_in(f4),
        .expected(expected), .a_out(a4), .b_out(b4), .c_out(c4), .busy(busy4),
        .done(done4), .truth_table(tt4), .match(match4)
    );

    bdd_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rstN), .start(start1), .abort(1'b0), .f_in(f1),
        .expected(8'hE8), .a_out(a1), .b_out(b1), .c_out(c1), .busy(busy1),
        .done(done1), .truth_table(tt1), .match(match1)
    );

    function automatic logic evalFunc(int sel, logic a, logic b, logic c);
        case (sel)
            0: return (a & b) | (a & c) | (b & c);
            1: return a ^ b ^ c;
            default: return 1'b1;
        endcase
    endfunction

    always_comb begin
        f4 = evalFunc(funcSel, a4, b4, c4);
        f1 = evalFunc(0, a1, b1, c1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rstN = 1'b0;
        tick();
        tick();
        rstN = 1'b1;
    endtask

    // Pulses start on the 4-cycle instance and stops in the FINISH cycle (or at the bound).
    task automatic runSweep4(output int busyCycles, output logic gotDone);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        busyCycles = 0;
        while (busy4 && busyCycles < 300) begin
            busyCycles++;
            tick();
        end
        gotDone = done4;
    endtask

    task automatic test_reset();
        doReset();
        checks++; if ({a4, b4, c4} !== 3'b000) begin failures++; $display("[TB] FAIL reset_abc got=%b exp=000", {a4, b4, c4}); end
        checks++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy_done got=%b%b exp=00", busy4, done4); end
        checks++; if (tt4 !== 8'h00 || match4 !== 1'b0) begin failures++; $display("[TB] FAIL reset_tt_match got=%h/%b exp=00/0", tt4, match4); end
    endtask

    task automatic test_majority();
        funcSel = 0;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (busy4 !== 1'b1 || {a4, b4, c4} !== 3'(i / 4)) begin
                failures++;
                $display("[TB] FAIL maj_step%0d got busy=%b abc=%b exp busy=1 abc=%b", i, busy4, {a4, b4, c4}, 3'(i / 4));
            end
            tick();
        end
        checks++; if (done4 !== 1'b1 || busy4 !== 1'b0) begin failures++; $display("[TB] FAIL maj_finish got done=%b busy=%b exp done=1 busy=0", done4, busy4); end
        checks++; if (tt4 !== 8'hE8) begin failures++; $display("[TB] FAIL maj_tt got=%h exp=e8", tt4); end
        checks++; if ({a4, b4, c4} !== 3'b000) begin failures++; $display("[TB] FAIL maj_finish_abc got=%b exp=000", {a4, b4, c4}); end
        tick();
        checks++; if (done4 !== 1'b0 || tt4 !== 8'hE8) begin failures++; $display("[TB] FAIL maj_idle got done=%b tt=%h exp done=0 tt=e8", done4, tt4); end
    endtask

    task automatic test_abort_priority();
        start4 = 1'b1;
        abort = 1'b1;
        tick();
        start4 = 1'b0;
        abort = 1'b0;
        checks++; if (busy4 !== 1'b0) begin failures++; $display("[TB] FAIL abort_prio_busy got=%b exp=0", busy4); end
        tick();
        checks++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin failures++; $display("[TB] FAIL abort_prio_later got=%b%b exp=00", busy4, done4); end
    endtask

    task automatic test_abort();
        doReset();
        funcSel = 2;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        checks++; if ({a4, b4, c4} !== 3'b010 || busy4 !== 1'b1) begin failures++; $display("[TB] FAIL abort_pre got abc=%b busy=%b exp abc=010 busy=1", {a4, b4, c4}, busy4); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin failures++; $display("[TB] FAIL abort_state got busy=%b done=%b exp 0 0", busy4, done4); end
        checks++; if (tt4 !== 8'h03) begin failures++; $display("[TB] FAIL abort_tt got=%h exp=03", tt4); end
        checks++; if ({a4, b4, c4} !== 3'b000) begin failures++; $display("[TB] FAIL abort_abc got=%b exp=000", {a4, b4, c4}); end
        tick();
        checks++; if (done4 !== 1'b0 || busy4 !== 1'b0) begin failures++; $display("[TB] FAIL abort_no_done got done=%b busy=%b exp 0 0", done4, busy4); end
    endtask

    task automatic test_reset_mid();
        int   n;
        logic d;
        funcSel = 2;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 21; i++) tick();
        checks++; if ({a4, b4, c4} !== 3'b101) begin failures++; $display("[TB] FAIL rstmid_pre_abc got=%b exp=101", {a4, b4, c4}); end
        rstN = 1'b0;
        tick();
        checks++; if ({a4, b4, c4, busy4, done4, match4} !== 6'b0 || tt4 !== 8'h00) begin failures++; $display("[TB] FAIL rstmid_outputs got abc=%b busy=%b done=%b match=%b tt=%h exp all 0", {a4, b4, c4}, busy4, done4, match4, tt4); end
        rstN = 1'b1;
        funcSel = 0;
        runSweep4(n, d);
        checks++; if (n != 32 || d !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_resweep got busy=%0d done=%b exp busy=32 done=1", n, d); end
        checks++; if (tt4 !== 8'hE8) begin failures++; $display("[TB] FAIL rstmid_tt got=%h exp=e8", tt4); end
        tick();
    endtask

    task automatic test_check();
        int   n;
        logic d;
        logic expMatch;
`ifdef BDD_SWEEP_CHECK_EN
        expMatch = 1'b1;
`else
        expMatch = 1'b0;
`endif
        funcSel = 1;
        expected = 8'h96;
        runSweep4(n, d);
        checks++; if (tt4 !== 8'h96 || n != 32) begin failures++; $display("[TB] FAIL xor_tt got tt=%h busy=%0d exp tt=96 busy=32", tt4, n); end
        tick();
        checks++; if (match4 !== expMatch) begin failures++; $display("[TB] FAIL match_96 got=%b exp=%b", match4, expMatch); end
        tick();
        checks++; if (match4 !== expMatch) begin failures++; $display("[TB] FAIL match_hold got=%b exp=%b", match4, expMatch); end
        expected = 8'h97;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        checks++; if (match4 !== 1'b0 || tt4 !== 8'h96) begin failures++; $display("[TB] FAIL start_clears got match=%b tt=%h exp match=0 tt=96", match4, tt4); end
        n = 0;
        while (busy4 && n < 300) begin n++; tick(); end
        tick();
        checks++; if (match4 !== 1'b0 || n != 32) begin failures++; $display("[TB] FAIL match_97 got match=%b busy=%0d exp match=0 busy=32", match4, n); end
    endtask

    task automatic test_back_to_back();
        int n;
        doReset();
        start1 = 1'b1;
        tick();
        for (int s = 0; s < 3; s++) begin
            n = 0;
            while (busy1 && n < 50) begin
                checks++;
                if ({a1, b1, c1} !== 3'(n)) begin failures++; $display("[TB] FAIL b2b_abc s%0d got=%b exp=%b", s, {a1, b1, c1}, 3'(n)); end
                n++;
                tick();
            end
            checks++; if (n != 8 || done1 !== 1'b1) begin failures++; $display("[TB] FAIL b2b_sweep%0d got busy=%0d done=%b exp busy=8 done=1", s, n, done1); end
            checks++; if (tt1 !== 8'hE8) begin failures++; $display("[TB] FAIL b2b_tt%0d got=%h exp=e8", s, tt1); end
            tick();
            checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle%0d got busy=%b done=%b exp 0 0", s, busy1, done1); end
            tick();
            checks++; if (busy1 !== 1'b1) begin failures++; $display("[TB] FAIL b2b_restart%0d got=%b exp=1", s, busy1); end
        end
        start1 = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        checks++; if (busy1 !== 1'b0) begin failures++; $display("[TB] FAIL b2b_stop got=%b exp=0", busy1); end
    endtask

    initial begin
        test_reset();
        test_majority();
        test_abort_priority();
        test_abort();
        test_reset_mid();
        test_check();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
